// File: rtl/mem_stage.sv
// Load/store stage: ALU packet in, data-memory req/ready handshake, aligned write-back packet out.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module mem_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] alu_val_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [4:0]      rd_i,
    input  logic [2:0]      funct3_i,
    output logic            stall_o,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            bus_err_o,
    output logic            misalign_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   tmo_cnt, tmo_cnt_n;
    logic [1:0]      cap_lo, cap_lo_n;
    logic [2:0]      cap_f3, cap_f3_n;
    logic            cap_m2r, cap_m2r_n;
    logic            cap_rw, cap_rw_n;
    logic [4:0]      cap_rd, cap_rd_n;
    logic [XLEN-1:0] cap_val, cap_val_n;

    logic            stall_n, req_n, we_n, wb_valid_n, wb_rw_n, bus_err_n, misalign_n;
    logic [XLEN-1:0] addr_n, wdata_n, wb_data_n;
    logic [3:0]      be_n;
    logic [4:0]      wb_rd_n;

    logic            mem_op, trap;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_ext;

    assign mem_op = mem_read_i | mem_write_i;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        trap = 1'b0;
        if (mem_op) begin
            case (funct3_i[1:0])
                2'b00:   trap = 1'b0;
                2'b01:   trap = alu_val_i[0];
                default: trap = (alu_val_i[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign trap = 1'b0;
`endif

    // Lane selection and extension of returning load data, from the captured address/size
    always_comb begin
        case (cap_lo)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = cap_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (cap_f3[1:0])
            2'b00:   load_ext = cap_f3[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                          : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = cap_f3[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                          : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_n    = state;
        tmo_cnt_n  = tmo_cnt;
        cap_lo_n   = cap_lo;
        cap_f3_n   = cap_f3;
        cap_m2r_n  = cap_m2r;
        cap_rw_n   = cap_rw;
        cap_rd_n   = cap_rd;
        cap_val_n  = cap_val;
        stall_n    = stall_o;
        req_n      = dmem_req;
        we_n       = dmem_we;
        addr_n     = dmem_addr;
        wdata_n    = dmem_wdata;
        be_n       = dmem_be;
        wb_valid_n = 1'b0;
        wb_rw_n    = 1'b0;
        wb_rd_n    = wb_rd;
        wb_data_n  = wb_data;
        bus_err_n  = 1'b0;
        misalign_n = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i && mem_op && !trap) begin
                    state_n   = ACCESS;
                    tmo_cnt_n = '0;
                    cap_lo_n  = alu_val_i[1:0];
                    cap_f3_n  = funct3_i;
                    cap_m2r_n = mem_to_reg_i;
                    cap_rw_n  = reg_write_i & ~mem_write_i;
                    cap_rd_n  = rd_i;
                    cap_val_n = alu_val_i;
                    stall_n   = 1'b1;
                    req_n     = 1'b1;
                    we_n      = mem_write_i;
                    addr_n    = {alu_val_i[XLEN-1:2], 2'b00};
                    case (funct3_i[1:0])
                        2'b00: begin
                            be_n    = 4'b0001 << alu_val_i[1:0];
                            wdata_n = {(XLEN/8){store_data_i[7:0]}};
                        end
                        2'b01: begin
                            be_n    = alu_val_i[1] ? 4'b1100 : 4'b0011;
                            wdata_n = {(XLEN/16){store_data_i[15:0]}};
                        end
                        default: begin
                            be_n    = 4'b1111;
                            wdata_n = store_data_i;
                        end
                    endcase
                end else if (valid_i) begin
                    // Plain ALU result, or a trapped misaligned access that never reaches the bus
                    wb_valid_n = 1'b1;
                    wb_rw_n    = reg_write_i & ~mem_op;
                    wb_rd_n    = rd_i;
                    wb_data_n  = alu_val_i;
                    misalign_n = trap;
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    state_n    = IDLE;
                    stall_n    = 1'b0;
                    req_n      = 1'b0;
                    wb_valid_n = 1'b1;
                    wb_rw_n    = cap_rw;
                    wb_rd_n    = cap_rd;
                    wb_data_n  = cap_m2r ? load_ext : cap_val;
                end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n    = IDLE;
                    stall_n    = 1'b0;
                    req_n      = 1'b0;
                    wb_valid_n = 1'b1;
                    wb_rd_n    = cap_rd;
                    wb_data_n  = cap_val;
                    bus_err_n  = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            cap_lo       <= '0;
            cap_f3       <= '0;
            cap_m2r      <= 1'b0;
            cap_rw       <= 1'b0;
            cap_rd       <= '0;
            cap_val      <= '0;
            stall_o      <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            bus_err_o    <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            state        <= state_n;
            tmo_cnt      <= tmo_cnt_n;
            cap_lo       <= cap_lo_n;
            cap_f3       <= cap_f3_n;
            cap_m2r      <= cap_m2r_n;
            cap_rw       <= cap_rw_n;
            cap_rd       <= cap_rd_n;
            cap_val      <= cap_val_n;
            stall_o      <= stall_n;
            dmem_req     <= req_n;
            dmem_we      <= we_n;
            dmem_addr    <= addr_n;
            dmem_wdata   <= wdata_n;
            dmem_be      <= be_n;
            wb_valid     <= wb_valid_n;
            wb_reg_write <= wb_rw_n;
            wb_rd        <= wb_rd_n;
            wb_data      <= wb_data_n;
            bus_err_o    <= bus_err_n;
            misalign_o   <= misalign_n;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: loads, stores, ALU pass-through, timeout, reset abort, misalignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
    logic [31:0] alu_val_i, store_data_i, dmem_rdata;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic        dmem_ready;
    logic        stall_o, dmem_req, dmem_we, wb_valid, wb_reg_write, bus_err_o, misalign_o;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alu_val_i(alu_val_i),
        .store_data_i(store_data_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i), .rd_i(rd_i),
        .funct3_i(funct3_i), .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0; reg_write_i = 0;
        alu_val_i = 0; store_data_i = 0; rd_i = 0; funct3_i = 0; dmem_ready = 0; dmem_rdata = 0;
    endtask

    // kind: 0=ALU, 1=load, 2=store
    task automatic present(input int kind, input logic [31:0] val, input logic [31:0] sd,
                           input logic [2:0] f3, input logic [4:0] rd);
        valid_i = 1; alu_val_i = val; store_data_i = sd; funct3_i = f3; rd_i = rd;
        mem_read_i = (kind == 1); mem_write_i = (kind == 2); mem_to_reg_i = (kind == 1);
        reg_write_i = 1;
    endtask

    task automatic test_reset();
        tests_run++; if ({stall_o, dmem_req, dmem_we, wb_valid, wb_reg_write, bus_err_o, misalign_o} !== 7'b0) begin tests_failed++; $display("[TB] FAIL reset_flags got %b exp 0", {stall_o, dmem_req, dmem_we, wb_valid, wb_reg_write, bus_err_o, misalign_o}); end
        tests_run++; if ({dmem_addr, dmem_wdata, wb_data} !== 96'b0) begin tests_failed++; $display("[TB] FAIL reset_data got %h %h %h exp 0", dmem_addr, dmem_wdata, wb_data); end
        tests_run++; if ({dmem_be, wb_rd} !== 9'b0) begin tests_failed++; $display("[TB] FAIL reset_be_rd got %b %d exp 0", dmem_be, wb_rd); end
    endtask

    task automatic test_alu();
        present(0, 32'h1234, 32'h0, 3'b010, 5'd5);
        tick();
        valid_i = 0;
        tests_run++; if ({wb_valid, wb_reg_write, dmem_req, stall_o} !== 4'b1100) begin tests_failed++; $display("[TB] FAIL alu_flags got %b exp 1100", {wb_valid, wb_reg_write, dmem_req, stall_o}); end
        tests_run++; if (wb_data !== 32'h1234 || wb_rd !== 5'd5) begin tests_failed++; $display("[TB] FAIL alu_wb got %h rd %0d exp 1234 rd 5", wb_data, wb_rd); end
        tick();
        tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL alu_pulse got %b exp 0", wb_valid); end
    endtask

    task automatic test_lb_wait();
        int stall_cycles = 0;
        present(1, 32'h103, 32'h0, 3'b000, 5'd7);
        tick();
        drive_idle();
        if (stall_o) stall_cycles++;
        tests_run++; if ({dmem_req, dmem_we} !== 2'b10 || dmem_addr !== 32'h100 || wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_req got req%b we%b addr %h wbv %b exp req1 we0 addr 100 wbv 0", dmem_req, dmem_we, dmem_addr, wb_valid); end
        tick();
        if (stall_o) stall_cycles++;
        tests_run++; if (dmem_req !== 1'b1 || wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_wait got req %b wbv %b exp 1 0", dmem_req, wb_valid); end
        dmem_ready = 1; dmem_rdata = 32'h80FF_FF12;
        tick();
        dmem_ready = 0;
        if (stall_o) stall_cycles++;
        tests_run++; if (wb_data !== 32'hFFFF_FF80 || {wb_valid, wb_reg_write, dmem_req} !== 3'b110 || wb_rd !== 5'd7) begin tests_failed++; $display("[TB] FAIL lb_wb got %h v%b rw%b req%b rd%0d exp ffffff80 1 1 0 7", wb_data, wb_valid, wb_reg_write, dmem_req, wb_rd); end
        tests_run++; if (stall_cycles !== 2) begin tests_failed++; $display("[TB] FAIL lb_stall got %0d exp 2", stall_cycles); end
    endtask

    // Zero-wait loads: {addr, funct3, rdata, expected}
    task automatic test_loads();
        logic [31:0] addrs [4] = '{32'h102, 32'h100, 32'h104, 32'h101};
        logic [2:0]  f3s   [4] = '{3'b101, 3'b001, 3'b010, 3'b100};
        logic [31:0] rds   [4] = '{32'h8001_1234, 32'h1234_8001, 32'hDEAD_BEEF, 32'h0000_9A00};
        logic [31:0] exps  [4] = '{32'h0000_8001, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_009A};
        for (int i = 0; i < 4; i++) begin
            present(1, addrs[i], 32'h0, f3s[i], 5'd9);
            tick();
            drive_idle();
            dmem_ready = 1; dmem_rdata = rds[i];
            tick();
            dmem_ready = 0;
            tests_run++; if (wb_data !== exps[i] || wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL load%0d got %h v%b exp %h v1", i, wb_data, wb_valid, exps[i]); end
        end
    endtask

    // Stores: {addr, funct3, data, be, wdata, bus addr}
    task automatic test_stores();
        logic [31:0] addrs [3] = '{32'h201, 32'h202, 32'h300};
        logic [2:0]  f3s   [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] sds   [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'hCAFE_F00D};
        logic [3:0]  bes   [3] = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] wds   [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'hCAFE_F00D};
        logic [31:0] bas   [3] = '{32'h200, 32'h200, 32'h300};
        for (int i = 0; i < 3; i++) begin
            present(2, addrs[i], sds[i], f3s[i], 5'd3);
            mem_to_reg_i = 0;
            tick();
            drive_idle();
            tests_run++; if (dmem_be !== bes[i] || dmem_wdata !== wds[i] || dmem_addr !== bas[i] || dmem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL store%0d got be %b wd %h a %h we %b exp %b %h %h 1", i, dmem_be, dmem_wdata, dmem_addr, dmem_we, bes[i], wds[i], bas[i]); end
            dmem_ready = 1;
            tick();
            dmem_ready = 0;
            tests_run++; if ({wb_valid, wb_reg_write} !== 2'b10) begin tests_failed++; $display("[TB] FAIL store%0d_wb got v%b rw%b exp 1 0", i, wb_valid, wb_reg_write); end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        logic seen = 0;
        present(1, 32'h400, 32'h0, 3'b010, 5'd4);
        tick();
        drive_idle();
        for (int i = 0; i < 40; i++) begin
            if (bus_err_o) begin seen = 1; break; end
            if (dmem_req) req_cycles++;
            tick();
        end
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL timeout_seen got 0 exp 1"); end
        tests_run++; if (req_cycles !== 16) begin tests_failed++; $display("[TB] FAIL timeout_len got %0d exp 16", req_cycles); end
        tests_run++; if ({wb_valid, wb_reg_write, dmem_req, stall_o} !== 4'b1000) begin tests_failed++; $display("[TB] FAIL timeout_wb got %b exp 1000", {wb_valid, wb_reg_write, dmem_req, stall_o}); end
        tick();
        tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_pulse got %b exp 0", bus_err_o); end
    endtask

    task automatic test_ready_last_cycle();
        present(1, 32'h500, 32'h0, 3'b010, 5'd6);
        tick();
        drive_idle();
        repeat (15) tick();
        dmem_ready = 1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_ready = 0;
        tests_run++; if ({wb_valid, wb_reg_write, bus_err_o} !== 3'b110 || wb_data !== 32'h5555_AAAA) begin tests_failed++; $display("[TB] FAIL last_ready got v%b rw%b err%b %h exp 1 1 0 5555aaaa", wb_valid, wb_reg_write, bus_err_o, wb_data); end
    endtask

    task automatic test_back_to_back();
        present(0, 32'h77, 32'h0, 3'b010, 5'd1);
        tick();
        present(1, 32'h600, 32'h0, 3'b010, 5'd2);
        tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'h77) begin tests_failed++; $display("[TB] FAIL b2b_alu got v%b %h exp 1 77", wb_valid, wb_data); end
        tick();
        drive_idle();
        tests_run++; if ({dmem_req, stall_o, wb_valid} !== 3'b110 || dmem_addr !== 32'h600) begin tests_failed++; $display("[TB] FAIL b2b_capture got %b %h exp 110 600", {dmem_req, stall_o, wb_valid}, dmem_addr); end
        dmem_ready = 1; dmem_rdata = 32'h0BAD_F00D;
        tick();
        dmem_ready = 0;
        present(0, 32'h88, 32'h0, 3'b000, 5'd8);
        tick();
        drive_idle();
        tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'h88 || wb_rd !== 5'd8) begin tests_failed++; $display("[TB] FAIL b2b_after_load got v%b %h rd%0d exp 1 88 8", wb_valid, wb_data, wb_rd); end
    endtask

    task automatic test_reset_mid_access();
        int wb_seen = 0;
        present(1, 32'h700, 32'h0, 3'b010, 5'd10);
        tick();
        drive_idle();
        tick();
        rst = 1;
        tick();
        tests_run++; if ({dmem_req, stall_o, wb_valid} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rst_mid got %b exp 000", {dmem_req, stall_o, wb_valid}); end
        rst = 0;
        dmem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_valid) wb_seen++;
        end
        dmem_ready = 0;
        tests_run++; if (wb_seen !== 0) begin tests_failed++; $display("[TB] FAIL rst_no_wb got %0d exp 0", wb_seen); end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        present(1, 32'h102, 32'h0, 3'b010, 5'd11);
        tick();
        drive_idle();
        tests_run++; if ({misalign_o, wb_valid, wb_reg_write, dmem_req, stall_o} !== 5'b11000) begin tests_failed++; $display("[TB] FAIL misalign_trap got %b exp 11000", {misalign_o, wb_valid, wb_reg_write, dmem_req, stall_o}); end
        tick();
        tests_run++; if ({misalign_o, dmem_req} !== 2'b00) begin tests_failed++; $display("[TB] FAIL misalign_pulse got %b exp 00", {misalign_o, dmem_req}); end
`else
        present(1, 32'h103, 32'h0, 3'b001, 5'd11);
        tick();
        drive_idle();
        tests_run++; if (dmem_req !== 1'b1 || misalign_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL misalign_noTrap got req %b mis %b exp 1 0", dmem_req, misalign_o); end
        dmem_ready = 1; dmem_rdata = 32'h8765_4321;
        tick();
        dmem_ready = 0;
        tests_run++; if (wb_data !== 32'hFFFF_8765) begin tests_failed++; $display("[TB] FAIL misalign_lane got %h exp ffff8765", wb_data); end
`endif
    endtask

    initial begin
        drive_idle();
        rst = 1;
        repeat (2) tick();
        test_reset();
        rst = 0;
        tick();
        test_alu();
        test_lb_wait();
        test_loads();
        test_stores();
        test_timeout();
        test_ready_last_cycle();
        test_back_to_back();
        test_reset_mid_access();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
